// File: rtl/ldpc_minsum_layered.sv
// Layered min-sum LDPC decoder with saturating W-bit LLRs and a serial bit load.
// Flow: IDLE -> LOAD (N serial bits) -> SYN (syndrome walk) -> [ITER -> SYN]* -> OUT.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle request, sampled only in IDLE, with init_mag and max_iter
//   init_mag            channel LLR magnitude (W-1 bits)
//   max_iter            iteration limit
//   in_valid, in_bit    serial received bits 0..N-1, honoured only in LOAD
//   busy                high in every state except IDLE (low in the done cycle)
//   out_valid, out_bit  N decoded bits in order 0..N-1
//   done                one-cycle pulse after the last out_valid
//   success, iter_count final syndrome-zero flag and iterations run, held until next start
module ldpc_minsum_layered #(
  parameter int unsigned N      = 8,
  parameter int unsigned M      = 4,
  parameter int unsigned DC     = 4,
  parameter int unsigned W      = 8,
  parameter logic [M*DC*$clog2(N)-1:0] COLS = {
    3'd7, 3'd3, 3'd2, 3'd1,
    3'd6, 3'd3, 3'd2, 3'd0,
    3'd5, 3'd3, 3'd1, 3'd0,
    3'd4, 3'd2, 3'd1, 3'd0},
  parameter int unsigned ITER_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [W-2:0]      init_mag,
  input  logic [ITER_W-1:0] max_iter,
  input  logic              in_valid,
  input  logic              in_bit,
  output logic              busy,
  output logic              out_valid,
  output logic              out_bit,
  output logic              done,
  output logic              success,
  output logic [ITER_W-1:0] iter_count
);

  localparam int unsigned CW = $clog2(N);
  localparam int unsigned RW = (M > 1) ? $clog2(M) : 1;
  localparam int unsigned JW = (DC > 1) ? $clog2(DC) : 1;
  localparam int unsigned OW = $clog2(N + 1);

  typedef enum logic [2:0] {StIdle, StLoad, StSyn, StIter, StOut} state_e;

  state_e state_q, state_d;

  logic [CW-1:0]     ld_q, ld_d;
  logic [RW-1:0]     row_q, row_d;
  logic [JW-1:0]     j_q, j_d;
  logic              wr_q, wr_d;         // ITER phase: 0 = read, 1 = write
  logic [OW-1:0]     out_q, out_d;       // out_q == N marks the done cycle
  logic              par_q, par_d;       // running parity of the current check
  logic              any_q, any_d;       // some earlier check had odd parity
  logic [W-2:0]      min1_q, min1_d;
  logic [W-2:0]      min2_q, min2_d;
  logic [JW-1:0]     idx_q, idx_d;
  logic              sx_q, sx_d;
  logic [W-2:0]      mag_q, mag_d;
  logic [ITER_W-1:0] maxit_q, maxit_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic              succ_q, succ_d;

  logic [W-1:0] l_q [N];
  logic [W-1:0] l_d [N];
  logic [W-1:0] r_q [M][DC];
  logic [W-1:0] r_d [M][DC];
  logic [W-1:0] qbuf_q [DC];
  logic [W-1:0] qbuf_d [DC];

  // Symmetric clip to +-(2^(W-1)-1); the most negative code never appears.
  function automatic logic [W-1:0] sat(input logic signed [W:0] x);
    logic signed [W:0] hi;
    logic signed [W:0] lo;
    hi = {2'b00, {(W-1){1'b1}}};
    lo = -hi;
    if (x > hi)      sat = hi[W-1:0];
    else if (x < lo) sat = lo[W-1:0];
    else             sat = x[W-1:0];
  endfunction

  logic [CW-1:0] cur_col;
  logic [W-1:0]  l_cur, r_cur, q_cur, q_neg;
  logic [W-2:0]  q_mag;
  logic [W-1:0]  qb, rn, pos_ld;
  logic [W-2:0]  wmag;
  logic          par_row;

  always_comb begin
    cur_col = COLS[(int'(row_q) * DC + int'(j_q)) * CW +: CW];
    l_cur   = l_q[cur_col];
    r_cur   = r_q[row_q][j_q];
    // Read phase: extrinsic message Q = sat(L - R) at W+1 bits.
    q_cur   = sat({l_cur[W-1], l_cur} - {r_cur[W-1], r_cur});
    q_neg   = -q_cur;
    q_mag   = q_cur[W-1] ? q_neg[W-2:0] : q_cur[W-2:0];
    // Write phase: new check message from the stored Q and the row minima.
    qb      = qbuf_q[j_q];
    wmag    = (j_q == idx_q) ? min2_q : min1_q;
    rn      = (sx_q ^ qb[W-1]) ? -{1'b0, wmag} : {1'b0, wmag};
    pos_ld  = {1'b0, mag_q};
    par_row = par_q ^ l_cur[W-1];
  end

  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    row_d   = row_q;
    j_d     = j_q;
    wr_d    = wr_q;
    out_d   = out_q;
    par_d   = par_q;
    any_d   = any_q;
    min1_d  = min1_q;
    min2_d  = min2_q;
    idx_d   = idx_q;
    sx_d    = sx_q;
    mag_d   = mag_q;
    maxit_d = maxit_q;
    iter_d  = iter_q;
    succ_d  = succ_q;
    l_d     = l_q;
    r_d     = r_q;
    qbuf_d  = qbuf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          mag_d   = init_mag;
          maxit_d = max_iter;
          iter_d  = '0;
          succ_d  = 1'b0;
          ld_d    = '0;
          for (int c = 0; c < int'(M); c++) begin
            for (int j = 0; j < int'(DC); j++) begin
              r_d[c][j] = '0;
            end
          end
        end
      end

      StLoad: begin
        if (in_valid) begin
          l_d[ld_q] = in_bit ? -pos_ld : pos_ld;
          if (ld_q == CW'(N - 1)) begin
            state_d = StSyn;
            row_d   = '0;
            j_d     = '0;
            par_d   = 1'b0;
            any_d   = 1'b0;
          end else begin
            ld_d = ld_q + 1'b1;
          end
        end
      end

      StSyn: begin
        if (j_q == JW'(DC - 1)) begin
          j_d   = '0;
          par_d = 1'b0;
          any_d = any_q | par_row;
          if (row_q == RW'(M - 1)) begin
            row_d = '0;
            if (!(any_q | par_row)) begin
              state_d = StOut;
              succ_d  = 1'b1;
              out_d   = '0;
            end else if (iter_q == maxit_q) begin
              state_d = StOut;
              succ_d  = 1'b0;
              out_d   = '0;
            end else begin
              state_d = StIter;
              wr_d    = 1'b0;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          j_d   = j_q + 1'b1;
          par_d = par_row;
        end
      end

      StIter: begin
        if (!wr_q) begin
          qbuf_d[j_q] = q_cur;
          if (j_q == '0) begin
            min1_d = q_mag;
            min2_d = '1;
            idx_d  = '0;
            sx_d   = q_cur[W-1];
          end else begin
            sx_d = sx_q ^ q_cur[W-1];
            // Strict compare keeps the lowest index on ties.
            if (q_mag < min1_q) begin
              min2_d = min1_q;
              min1_d = q_mag;
              idx_d  = j_q;
            end else if (q_mag < min2_q) begin
              min2_d = q_mag;
            end
          end
          if (j_q == JW'(DC - 1)) begin
            j_d  = '0;
            wr_d = 1'b1;
          end else begin
            j_d = j_q + 1'b1;
          end
        end else begin
          l_d[cur_col]     = sat({qb[W-1], qb} + {rn[W-1], rn});
          r_d[row_q][j_q]  = rn;
          if (j_q == JW'(DC - 1)) begin
            j_d  = '0;
            wr_d = 1'b0;
            if (row_q == RW'(M - 1)) begin
              row_d   = '0;
              iter_d  = iter_q + 1'b1;
              state_d = StSyn;
              par_d   = 1'b0;
              any_d   = 1'b0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end

      StOut: begin
        if (out_q == OW'(N)) begin
          state_d = StIdle;
        end else begin
          out_d = out_q + 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      ld_q    <= '0;
      row_q   <= '0;
      j_q     <= '0;
      wr_q    <= 1'b0;
      out_q   <= '0;
      par_q   <= 1'b0;
      any_q   <= 1'b0;
      min1_q  <= '0;
      min2_q  <= '0;
      idx_q   <= '0;
      sx_q    <= 1'b0;
      mag_q   <= '0;
      maxit_q <= '0;
      iter_q  <= '0;
      succ_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      row_q   <= row_d;
      j_q     <= j_d;
      wr_q    <= wr_d;
      out_q   <= out_d;
      par_q   <= par_d;
      any_q   <= any_d;
      min1_q  <= min1_d;
      min2_q  <= min2_d;
      idx_q   <= idx_d;
      sx_q    <= sx_d;
      mag_q   <= mag_d;
      maxit_q <= maxit_d;
      iter_q  <= iter_d;
      succ_q  <= succ_d;
    end
  end

  // Message storage carries no reset; contents are rewritten before use.
  always_ff @(posedge clk) begin
    l_q    <= l_d;
    r_q    <= r_d;
    qbuf_q <= qbuf_d;
  end

  always_comb begin
    done       = (state_q == StOut) && (out_q == OW'(N));
    out_valid  = (state_q == StOut) && (out_q < OW'(N));
    busy       = (state_q != StIdle) && !done;
    out_bit    = out_valid & l_q[out_q[CW-1:0]][W-1];
    success    = succ_q;
    iter_count = iter_q;
  end

endmodule

// File: tb/tb_ldpc_minsum_layered.sv
// Directed bench for ldpc_minsum_layered: clean word, single flip, max_iter = 0,
// ignored start/in_valid, stalled load, and mid-ITER reset.
module tb_ldpc_minsum_layered;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [6:0]  init_mag;
  logic [15:0] max_iter;
  logic        in_valid;
  logic        in_bit;
  logic        busy;
  logic        out_valid;
  logic        out_bit;
  logic        done;
  logic        success;
  logic [15:0] iter_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t      = 0;

  ldpc_minsum_layered dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .init_mag  (init_mag),
    .max_iter  (max_iter),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .busy      (busy),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .done      (done),
    .success   (success),
    .iter_count(iter_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [6:0] mag, input logic [15:0] mi);
    @(negedge clk);
    start    = 1'b1;
    init_mag = mag;
    max_iter = mi;
    @(negedge clk);
    start    = 1'b0;
  endtask

  // One beat per cycle, with `gap` idle cycles between beats; t = last beat cycle.
  task automatic load_word(input logic [7:0] bits, input int gap);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_bit   = bits[i];
      t        = cyc;
      if (i < 7) begin
        repeat (gap) begin
          @(negedge clk);
          in_valid = 1'b0;
          in_bit   = 1'b0;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_bit   = 1'b0;
  endtask

  task automatic run_check(input string tag, input logic [7:0] exp_bits, input logic exp_succ,
                           input int exp_iter, input int exp_off, input bit inject);
    int rel;
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 400; k++) begin
      rel = cyc - t;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      if (inject && (rel == 3 || rel == 30 || rel == 50)) begin
        start = 1'b1; in_valid = 1'b1; in_bit = 1'b1;
      end else begin
        start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0; in_valid = 1'b0; in_bit = 1'b0;
    chk({tag, "_out_seen"}, 32'(seen), 32'd1);
    chk({tag, "_out_start"}, cyc - t, exp_off);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_bit"}, 32'(out_bit), 32'(exp_bits[i]));
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_done_t"}, cyc - t, exp_off + 8);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    chk({tag, "_valid_done"}, 32'(out_valid), 32'd0);
    chk({tag, "_success"}, 32'(success), 32'(exp_succ));
    chk({tag, "_iter"}, 32'(iter_count), exp_iter);
    @(negedge clk);
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_success_hold"}, 32'(success), 32'(exp_succ));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; init_mag = '0; max_iter = '0; in_valid = 1'b0; in_bit = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_success", 32'(success), 32'd0);
    chk("rst_iter", 32'(iter_count), 32'd0);
    rst_n = 1'b1;

    // in_valid while idle must not start anything
    @(negedge clk);
    in_valid = 1'b1; in_bit = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_bit = 1'b0;
    chk("idle_invalid_busy", 32'(busy), 32'd0);

    // Clean all-zero word
    do_start(7'd4, 16'd10);
    chk("s1_busy_load", 32'(busy), 32'd1);
    load_word(8'h00, 0);
    run_check("s1", 8'h00, 1'b1, 0, 17, 1'b0);

    // Bit 0 flipped, one iteration repairs it
    do_start(7'd4, 16'd10);
    load_word(8'h01, 0);
    run_check("s2", 8'h00, 1'b1, 1, 65, 1'b0);

    // Reset while idle clears held results
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("idle_rst_success", 32'(success), 32'd0);
    chk("idle_rst_iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // max_iter = 0: raw bits out, failure reported
    do_start(7'd4, 16'd0);
    load_word(8'h01, 0);
    run_check("s3", 8'h01, 1'b0, 0, 17, 1'b0);

    // Stray start / in_valid during SYN and ITER are ignored
    do_start(7'd4, 16'd10);
    load_word(8'h01, 0);
    run_check("s4", 8'h00, 1'b1, 1, 65, 1'b1);

    // Stalled load, beat every third cycle
    do_start(7'd4, 16'd10);
    load_word(8'h00, 2);
    run_check("s5", 8'h00, 1'b1, 0, 17, 1'b0);

    // Reset in the middle of ITER
    do_start(7'd4, 16'd10);
    load_word(8'h01, 0);
    while (cyc - t < 30) @(negedge clk);
    chk("s6_busy_pre", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s6_busy", 32'(busy), 32'd0);
    chk("s6_valid", 32'(out_valid), 32'd0);
    chk("s6_bit", 32'(out_bit), 32'd0);
    chk("s6_done", 32'(done), 32'd0);
    chk("s6_success", 32'(success), 32'd0);
    chk("s6_iter", 32'(iter_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    do_start(7'd4, 16'd10);
    load_word(8'h00, 0);
    run_check("s7", 8'h00, 1'b1, 0, 17, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
